// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter.
// Requester i occupies slice [i*W +: W] of each packed per-port vector.
interface mem_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MBE_WIDTH  = 4
);
  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  // Requester side
  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*MBE_WIDTH-1:0]  req_mbe;
  logic [LINE_WIDTH-1:0]           req_rdata;
  logic [NUM_PORTS-1:0]            req_resp;

  // Memory side
  logic                            mem_read;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [LINE_WIDTH-1:0]           mem_wdata;
  logic [MBE_WIDTH-1:0]            mem_byte_enable;
  logic [LINE_WIDTH-1:0]           mem_rdata;
  logic                            mem_resp;

  // Current owner
  logic                            grant_valid;
  logic [IdxW-1:0]                 grant_idx;

  // Arbiter view: owns the memory bus and the grant.
  modport master (
    input  req_read, req_write, req_addr, req_wdata, req_mbe,
    input  mem_rdata, mem_resp,
    output req_rdata, req_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output grant_valid, grant_idx
  );

  // Environment view: requesters plus the memory model.
  modport slave (
    output req_read, req_write, req_addr, req_wdata, req_mbe,
    output mem_rdata, mem_resp,
    input  req_rdata, req_resp,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  grant_valid, grant_idx
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-port cache-to-memory arbiter, round-robin by default; defining
// MEM_ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins).
module mem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MBE_WIDTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_idx_q, grant_idx_d;

  logic [NUM_PORTS-1:0] requesting;
  logic [NUM_PORTS-1:0] served_mask;
  logic [NUM_PORTS-1:0] arb_cand;
  logic [IdxW-1:0]      arb_start;
  logic [IdxW-1:0]      cand_idx;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_found;
  logic                 grant_take;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [LINE_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [MBE_WIDTH-1:0]  mbe_arr   [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : gen_unpack
    assign addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = bus.req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
    assign mbe_arr[i]   = bus.req_mbe[i*MBE_WIDTH +: MBE_WIDTH];
  end

  assign requesting = bus.req_read | bus.req_write;

  always_comb begin
    served_mask = '0;
    served_mask[grant_idx_q] = 1'b1;
  end

  // While busy only a response re-arbitrates, and the port just served sits out.
  assign arb_cand = (state_q == StBusy) ? (requesting & ~served_mask) : requesting;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign arb_start = '0;
`else
  logic [IdxW-1:0] last_grant_q, last_grant_d;

  assign arb_start = (last_grant_q == IdxW'(NUM_PORTS - 1)) ? '0 : last_grant_q + IdxW'(1);
  assign last_grant_d = grant_take ? arb_idx : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IdxW'(NUM_PORTS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Circular search from arb_start; first candidate found wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      cand_idx = IdxW'((32'(arb_start) + off) % NUM_PORTS);
      if (!arb_found && arb_cand[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_take  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d    = StBusy;
          grant_take = 1'b1;
        end
      end
      StBusy: begin
        if (bus.mem_resp) begin
          if (arb_found) begin
            grant_take = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (!requesting[grant_idx_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant_take) begin
      grant_idx_d = arb_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    bus.req_resp        = '0;
    if (state_q == StBusy) begin
      bus.mem_read              = bus.req_read[grant_idx_q];
      bus.mem_write             = bus.req_write[grant_idx_q];
      bus.mem_address           = addr_arr[grant_idx_q];
      bus.mem_wdata             = wdata_arr[grant_idx_q];
      bus.mem_byte_enable       = mbe_arr[grant_idx_q];
      bus.req_resp[grant_idx_q] = bus.mem_resp;
    end
  end

  assign bus.req_rdata   = bus.mem_rdata;
  assign bus.grant_valid = (state_q == StBusy);
  assign bus.grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each
// grant into a queue; a negedge monitor pops and checks what the DUT presents.
module tb_mem_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MBE_WIDTH(MW)) bus ();

  mem_arbiter #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MBE_WIDTH(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [MW-1:0] mbe;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];

  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = NP - 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Next owner: first requester in rotation order, skipping the port just served.
  function automatic int pick(input logic [NP-1:0] reqv, input int served, input int last);
    int p;
    for (int k = 0; k < NP; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      p = k;
`else
      p = (last + 1 + k) % NP;
`endif
      if (p != served && reqv[p]) return p;
    end
    return -1;
  endfunction

  // Reference model: advances on the same edge the DUT does, pushes each predicted grant.
  always @(posedge clk) begin : model
    logic [NP-1:0] reqv;
    int            served;
    int            w;
    bit            arb;
    reqv = bus.req_read | bus.req_write;
    if (rst) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = NP - 1;
    end else begin
      arb    = 1'b0;
      served = -1;
      if (!m_busy) begin
        arb = 1'b1;
      end else if (bus.mem_resp) begin
        arb    = 1'b1;
        served = m_owner;
      end else if (!reqv[m_owner]) begin
        m_busy = 1'b0;
      end
      if (arb) begin
        w = pick(reqv, served, m_last);
        if (w < 0) begin
          m_busy = 1'b0;
        end else begin
          m_busy  = 1'b1;
          m_owner = w;
          m_last  = w;
          exp_q.push_back('{port: w, addr: bus.req_addr[w*AW +: AW],
                            wdata: bus.req_wdata[w*LW +: LW], mbe: bus.req_mbe[w*MW +: MW]});
        end
      end
    end
  end

  bit   prev_gv   = 1'b0;
  bit   prev_resp = 1'b0;
  bit   have_cur  = 1'b0;
  exp_t cur;

  always @(negedge clk) begin : monitor
    logic [NP-1:0] resp_exp;
    if (bus.grant_valid && (!prev_gv || prev_resp)) begin
      grant_log.push_back(int'(bus.grant_idx));
      chk("grant_predicted", LW'(exp_q.size() != 0), LW'(1));
      if (exp_q.size() != 0) begin
        cur      = exp_q.pop_front();
        have_cur = 1'b1;
      end else begin
        have_cur = 1'b0;
      end
    end
    chk("grant_valid", LW'(bus.grant_valid), LW'(m_busy));
    resp_exp = '0;
    if (m_busy && bus.mem_resp) resp_exp[m_owner] = 1'b1;
    chk("req_resp", LW'(bus.req_resp), LW'(resp_exp));
    chk("req_rdata", bus.req_rdata, bus.mem_rdata);
    if (bus.grant_valid && have_cur) begin
      chk("grant_idx", LW'(bus.grant_idx), LW'(cur.port));
      chk("mem_address", LW'(bus.mem_address), LW'(cur.addr));
      chk("mem_wdata", bus.mem_wdata, cur.wdata);
      chk("mem_byte_enable", LW'(bus.mem_byte_enable), LW'(cur.mbe));
      chk("mem_read", LW'(bus.mem_read), LW'(bus.req_read[cur.port]));
      chk("mem_write", LW'(bus.mem_write), LW'(bus.req_write[cur.port]));
    end else if (!bus.grant_valid) begin
      chk("idle_outputs", LW'({bus.mem_read, bus.mem_write, bus.mem_address,
                              bus.mem_byte_enable, |bus.mem_wdata}), '0);
    end
    prev_gv   = bus.grant_valid;
    prev_resp = bus.grant_valid && bus.mem_resp;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.mem_resp  = 1'b0;
  endtask

  task automatic new_txn(input int i);
    int rw;
    rw = int'($urandom_range(7));
    bus.req_read[i]  = (rw < 3) || (rw == 7);
    bus.req_write[i] = (rw >= 3);
    bus.req_addr[i*AW +: AW] = $urandom();
    for (int w = 0; w < int'(LW / 32); w++) bus.req_wdata[i*LW + w*32 +: 32] = $urandom();
    bus.req_mbe[i*MW +: MW] = MW'($urandom());
  endtask

  int exp_order[8];
  bit act[NP];
  bit done[NP];
  bit withdrew;
  int n;

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    clear_reqs();
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mbe   = '0;
    bus.mem_rdata = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_grant_valid", LW'(bus.grant_valid), LW'(0));
    chk("reset_grant_idx", LW'(bus.grant_idx), LW'(0));

    // Two readers after reset: port 0 wins, one cycle latency, then back-to-back to port 1.
    tick();
    bus.req_addr[0*AW +: AW] = 32'h0000_1000;
    bus.req_addr[1*AW +: AW] = 32'h0000_2000;
    bus.req_read = 4'b0011;
    @(negedge clk);
    chk("r032_no_read_same_cycle", LW'(bus.mem_read), LW'(0));
    tick();
    @(negedge clk);
    chk("r032_grant_idx", LW'(bus.grant_idx), LW'(0));
    chk("r032_mem_read", LW'(bus.mem_read), LW'(1));
    chk("r032_mem_address", LW'(bus.mem_address), LW'(32'h0000_1000));
    tick();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    chk("r033_req_resp", LW'(bus.req_resp), LW'(4'b0001));
    tick();
    bus.req_read[0] = 1'b0;
    bus.mem_resp    = 1'b0;
    @(negedge clk);
    chk("r033_grant_valid", LW'(bus.grant_valid), LW'(1));
    chk("r033_grant_idx", LW'(bus.grant_idx), LW'(1));
    chk("r033_req_resp_quiet", LW'(bus.req_resp), LW'(0));
    tick();
    bus.mem_resp = 1'b1;
    tick();
    clear_reqs();

    // Port 2 masked write.
    tick();
    bus.req_addr[2*AW +: AW]  = 32'hCAFE_0040;
    bus.req_wdata[2*LW +: LW] = {32{8'hA5}};
    bus.req_mbe[2*MW +: MW]   = 4'b1010;
    bus.req_write[2]          = 1'b1;
    tick();
    @(negedge clk);
    chk("r035_mem_write", LW'(bus.mem_write), LW'(1));
    chk("r035_mbe", LW'(bus.mem_byte_enable), LW'(4'b1010));
    chk("r035_wdata", bus.mem_wdata, {32{8'hA5}});
    tick();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    chk("r035_req_resp", LW'(bus.req_resp), LW'(4'b0100));
    tick();
    clear_reqs();

    // Reset while busy drops the transaction; port 3 is then granted.
    tick();
    bus.req_read[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("r036_busy_read", LW'(bus.mem_read), LW'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_read = 4'b1000;
    @(negedge clk);
    chk("r036_mem_read_dropped", LW'(bus.mem_read), LW'(0));
    chk("r036_grant_valid_dropped", LW'(bus.grant_valid), LW'(0));
    tick();
    @(negedge clk);
    chk("r036_grant_valid", LW'(bus.grant_valid), LW'(1));
    chk("r036_grant_idx", LW'(bus.grant_idx), LW'(3));
    tick();
    bus.mem_resp = 1'b1;
    tick();
    clear_reqs();

    // Owner withdraws without a response: abort back to idle.
    tick();
    bus.req_read[1] = 1'b1;
    tick();
    tick();
    bus.req_read[1] = 1'b0;
    @(negedge clk);
    chk("abort_still_busy", LW'(bus.grant_valid), LW'(1));
    chk("abort_read_low", LW'(bus.mem_read), LW'(0));
    tick();
    @(negedge clk);
    chk("abort_idle", LW'(bus.grant_valid), LW'(0));

    // Saturated load from reset: grant order.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grant_log.delete();
    bus.req_read = 4'b1111;
    bus.mem_resp = 1'b1;
    n = 0;
    while (grant_log.size() < 8 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    clear_reqs();
    chk("r034_grant_count", LW'(grant_log.size() >= 8), LW'(1));
    for (int k = 0; k < 8; k++) begin
      if (k < grant_log.size()) chk($sformatf("r034_order_%0d", k), LW'(grant_log[k]),
                                    LW'(exp_order[k]));
    end
    tick();
    tick();

    // Randomized traffic with a random-latency memory.
    for (int i = 0; i < int'(NP); i++) begin
      act[i]  = 1'b0;
      done[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < int'(NP); i++) begin
        withdrew = 1'b0;
        if (act[i] && done[i]) begin
          act[i] = 1'b0;
        end else if (act[i] && $urandom_range(63) == 0) begin
          act[i]   = 1'b0;
          withdrew = 1'b1;
        end
        if (!act[i] && !withdrew && $urandom_range(2) == 0) begin
          act[i] = 1'b1;
          new_txn(i);
        end
        if (!act[i]) begin
          bus.req_read[i]  = 1'b0;
          bus.req_write[i] = 1'b0;
        end
      end
      for (int w = 0; w < int'(LW / 32); w++) bus.mem_rdata[w*32 +: 32] = $urandom();
      #1;
      bus.mem_resp = (bus.mem_read || bus.mem_write) && ($urandom_range(2) == 0);
      #1;
      for (int i = 0; i < int'(NP); i++) done[i] = bus.req_resp[i];
    end
    tick();
    clear_reqs();
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("scoreboard_drained", LW'(exp_q.size()), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
